// File: rtl/hblur_pipe.sv
// Horizontal box blur: per-line 2^k tap average of NCH colour channels over the
// newest pixels of the line, with zero-fill or edge-replicate line starts.

module hblur_lane #(
  parameter int CH_W     = 8,
  parameter int MAX_LOG2 = 3,
  parameter int TAP_W    = 2,
  parameter int HIST     = 7
) (
  input  logic [CH_W-1:0]            i_px,
  input  logic [HIST-1:0][CH_W-1:0]  i_hist,
  input  logic [TAP_W-1:0]           i_k,
  output logic [CH_W-1:0]            o_avg
);
  localparam int SW = CH_W + MAX_LOG2;

  logic [SW-1:0] w_sum;
  logic [SW-1:0] w_shift;

  // Masked sum: history entry j takes part only when it lies inside the 2^k window.
  always_comb begin
    w_sum = SW'(i_px);
    for (int j = 0; j < HIST; j++) begin
      if (j < (1 << i_k) - 1) w_sum = w_sum + SW'(i_hist[j]);
    end
    w_shift = w_sum >> i_k;
    o_avg   = w_shift[CH_W-1:0];
  end
endmodule

module hblur_pipe #(
  parameter int CH_W     = 8,
  parameter int NCH      = 3,
  parameter int MAX_LOG2 = 3
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          in_valid,
  input  logic                          sol,
  input  logic                          edge_rep,
  input  logic [$clog2(MAX_LOG2+1)-1:0] tap_sel,
  input  logic [CH_W*(NCH+1)-1:0]       data,
  output logic                          out_valid,
  output logic [CH_W*(NCH+1)-1:0]       blur,
  output logic                          warm
);
  localparam int PW     = CH_W * (NCH + 1);
  localparam int TAP_W  = $clog2(MAX_LOG2 + 1);
  localparam int DEPTH  = 2 ** MAX_LOG2;
  localparam int HIST   = DEPTH - 1;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int STAGES = 1;

  typedef logic [NCH-1:0][CH_W-1:0] px_t;

  typedef struct packed {
    logic             first;
    logic             rep;
    logic [TAP_W-1:0] k;
    px_t              px;
  } req_t;

  req_t                        w_req;
  logic [TAP_W-1:0]            w_k_clamp;
  logic [TAP_W-1:0]            w_k_eff;
  logic                        w_rep_eff;
  logic [HIST-1:0][NCH-1:0][CH_W-1:0] w_hist_eff;
  logic [NCH-1:0][HIST-1:0][CH_W-1:0] w_col;
  px_t                         w_avg;
  logic [CW-1:0]               w_cnt_nxt;
  logic                        w_warm;
  logic                        w_unused_alpha;

  logic [HIST-1:0][NCH-1:0][CH_W-1:0] r_hist;
  logic [CW-1:0]               r_cnt;
  logic [TAP_W-1:0]            r_k;
  logic                        r_rep;
  logic [STAGES-1:0]           r_vld_pipe;
  px_t                         r_blur;
  logic                        r_warm;

  assign w_unused_alpha = ^data[PW-1 -: CH_W];

  always_comb begin
    w_k_clamp   = (tap_sel > TAP_W'(MAX_LOG2)) ? TAP_W'(MAX_LOG2) : tap_sel;
    w_req.first = in_valid & sol;
    w_req.rep   = edge_rep;
    w_req.k     = w_k_clamp;
    w_req.px    = px_t'(data[NCH*CH_W-1:0]);
  end

  // A line start overrides the latched controls and history for its own pixel.
  always_comb begin
    w_k_eff   = w_req.first ? w_req.k   : r_k;
    w_rep_eff = w_req.first ? w_req.rep : r_rep;
    for (int j = 0; j < HIST; j++) begin
      if (w_req.first) w_hist_eff[j] = w_req.rep ? w_req.px : '0;
      else             w_hist_eff[j] = r_hist[j];
    end
  end

  always_comb begin
    w_col = '0;
    for (int c = 0; c < NCH; c++)
      for (int j = 0; j < HIST; j++)
        w_col[c][j] = w_hist_eff[j][c];
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    hblur_lane #(
      .CH_W     (CH_W),
      .MAX_LOG2 (MAX_LOG2),
      .TAP_W    (TAP_W),
      .HIST     (HIST)
    ) u_lane (
      .i_px   (w_req.px[c]),
      .i_hist (w_col[c]),
      .i_k    (w_k_eff),
      .o_avg  (w_avg[c])
    );
  end

  // Fill count includes the pixel being accepted; saturates at the full window.
  always_comb begin
    if (w_req.first)                w_cnt_nxt = CW'(1);
    else if (r_cnt == CW'(DEPTH))   w_cnt_nxt = r_cnt;
    else                            w_cnt_nxt = r_cnt + CW'(1);
    w_warm = (int'(w_cnt_nxt) >= (1 << w_k_eff)) | w_rep_eff;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_hist     <= '0;
      r_cnt      <= '0;
      r_k        <= TAP_W'(MAX_LOG2);
      r_rep      <= 1'b0;
      r_vld_pipe <= '0;
      r_blur     <= '0;
      r_warm     <= 1'b0;
    end else begin
      r_vld_pipe <= STAGES'({r_vld_pipe, in_valid});
      if (in_valid) begin
        r_hist[0] <= w_req.px;
        for (int j = 1; j < HIST; j++) r_hist[j] <= w_hist_eff[j-1];
        r_cnt  <= w_cnt_nxt;
        r_k    <= w_k_eff;
        r_rep  <= w_rep_eff;
        r_blur <= w_avg;
        r_warm <= w_warm;
      end
    end
  end

  assign out_valid = r_vld_pipe[STAGES-1];
  assign blur      = {{CH_W{1'b1}}, r_blur};
  assign warm      = r_warm;
endmodule

// File: tb/tb_hblur_pipe.sv
// Bench for hblur_pipe: directed line scenarios plus random traffic, all checked
// against a per-line pixel-list reference model.

module tb_hblur_pipe;
  localparam int CH_W = 8, NCH = 3, MAX_LOG2 = 3;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        in_valid = 1'b0, sol = 1'b0, edge_rep = 1'b0;
  logic [1:0]  tap_sel = 2'd0;
  logic [31:0] data = 32'h0;
  logic        out_valid, warm;
  logic [31:0] blur;

  hblur_pipe #(.CH_W(CH_W), .NCH(NCH), .MAX_LOG2(MAX_LOG2)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .sol(sol),
    .edge_rep(edge_rep), .tap_sel(tap_sel), .data(data),
    .out_valid(out_valid), .blur(blur), .warm(warm)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Model state: every pixel of the current line, plus the line's controls.
  logic [23:0] line[$];
  int          m_k;
  bit          m_rep;
  logic [31:0] exp_blur;
  logic        exp_warm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    line.delete();
    m_k = MAX_LOG2; m_rep = 1'b0;
    exp_blur = 32'hff000000; exp_warm = 1'b0;
  endtask

  task automatic model(input bit s, input bit e, input logic [1:0] t, input logic [31:0] d);
    int n, idx, sum;
    logic [23:0] px, res;
    if (s) begin
      line.delete();
      m_k = (int'(t) > MAX_LOG2) ? MAX_LOG2 : int'(t);
      m_rep = e;
    end
    line.push_back(d[23:0]);
    n = line.size();
    res = '0;
    for (int c = 0; c < NCH; c++) begin
      sum = 0;
      for (int j = 0; j < (1 << m_k); j++) begin
        idx = n - 1 - j;
        if (idx >= 0) px = line[idx];
        else          px = m_rep ? line[0] : 24'h0;
        sum += int'(px[c*8 +: 8]);
      end
      res[c*8 +: 8] = 8'(sum / (1 << m_k));
    end
    exp_blur = {8'hff, res};
    exp_warm = (((n > 8) ? 8 : n) >= (1 << m_k)) || m_rep;
  endtask

  task automatic step(input bit v, input bit s, input bit e, input logic [1:0] t,
                      input logic [31:0] d);
    in_valid = v; sol = s; edge_rep = e; tap_sel = t; data = d;
    if (v) model(s, e, t, d);
    @(posedge clk); #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, v});
    chk("blur", blur, exp_blur);
    chk("warm", {31'd0, warm}, {31'd0, exp_warm});
  endtask

  task automatic do_reset();
    in_valid = 0; sol = 0;
    n_rst = 1'b0;
    model_reset();
    #2;
    chk("rst_blur", blur, 32'hff000000);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_warm", {31'd0, warm}, 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h0);

    // Zero-fill ramp, 8 taps
    step(1, 1, 0, 3, 32'hffffffff);
    chk("ramp1", blur, 32'hff1f1f1f);
    chk("ramp1_warm", {31'd0, warm}, 32'd0);
    step(1, 0, 0, 3, 32'hffffffff);
    chk("ramp2", blur, 32'hff3f3f3f);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 3, 32'hffffffff);
    chk("ramp7_warm", {31'd0, warm}, 32'd0);
    step(1, 0, 0, 3, 32'hffffffff);
    chk("ramp8", blur, 32'hffffffff);
    chk("ramp8_warm", {31'd0, warm}, 32'd1);

    // Edge replicate, 2 taps
    step(1, 1, 1, 1, 32'h00102030);
    chk("rep1", blur, 32'hff102030);
    chk("rep1_warm", {31'd0, warm}, 32'd1);
    step(1, 0, 0, 1, 32'h00000000);
    chk("rep2", blur, 32'hff081018);

    // Window sizes
    step(1, 1, 0, 0, 32'h12345678);
    chk("k0", blur, 32'hff345678);
    chk("k0_warm", {31'd0, warm}, 32'd1);
    step(1, 1, 0, 2, 32'h00040404);
    chk("k2_1", blur, 32'hff010101);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 2, 32'h00040404);
    chk("k2_4", blur, 32'hff040404);

    // Mid-line tap change is ignored; next sol restarts fill
    step(1, 1, 0, 3, $urandom);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, $urandom);
    step(1, 1, 0, 1, $urandom);
    chk("sol_warm", {31'd0, warm}, 32'd0);

    // Gaps
    step(1, 1, 0, 2, $urandom);
    step(0, 0, 0, 2, $urandom);
    step(1, 0, 0, 2, $urandom);
    step(0, 1, 1, 0, $urandom);
    step(1, 0, 0, 0, $urandom);

    // Mid-line reset, then a line without sol
    step(1, 1, 1, 2, $urandom);
    step(1, 0, 0, 2, $urandom);
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1, $urandom);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      bit v, s;
      v = ($urandom % 4) != 0;
      s = v && (($urandom % 7) == 0);
      step(v, s, 1'($urandom), 2'($urandom), $urandom);
      if (i == 400) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
